// File: rtl/serial_cmp_pkg.sv
// Shared types and defaults for the serial comparator family (serializer and comparators).
package serial_cmp_pkg;

    typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;

    localparam int SER_W_DEFAULT = 8;

endpackage

// File: rtl/serial_word_serializer.sv
// Parallel-to-serial front end: streams an operand pair one bit pair per transfer with first/last framing.
// Define SERIALIZER_LSB_FIRST_EN to stream bit 0 first instead of bit W-1.
module serial_word_serializer
    import serial_cmp_pkg::*;
#(
    parameter int W = SER_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         ser_valid,
    input  logic         ser_ready,
    output logic         ser_a,
    output logic         ser_b,
    output logic         ser_first,
    output logic         ser_last
);

    localparam int            CW      = $clog2(W);
    localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);
`ifdef SERIALIZER_LSB_FIRST_EN
    localparam int            OUT_IDX = 0;
`else
    localparam int            OUT_IDX = W - 1;
`endif

    ser_state_t    state_q, state_d;
    logic [W-1:0]  sh_a_q, sh_a_d;
    logic [W-1:0]  sh_b_q, sh_b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_shift;
    logic          accept;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SER_IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: acceptance takes priority so a new word can follow the last bit with no bubble
    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = SER_SHIFT;
            sh_a_d  = in_a;
            sh_b_d  = in_b;
            cnt_d   = CNT_TOP;
        end else if (state_q == SER_SHIFT && ser_ready) begin
            if (cnt_q == '0) begin
                state_d = SER_IDLE;
            end else begin
`ifdef SERIALIZER_LSB_FIRST_EN
                sh_a_d = {1'b0, sh_a_q[W-1:1]};
                sh_b_d = {1'b0, sh_b_q[W-1:1]};
`else
                sh_a_d = {sh_a_q[W-2:0], 1'b0};
                sh_b_d = {sh_b_q[W-2:0], 1'b0};
`endif
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    // Outputs: bit outputs are gated by state so IDLE always presents zeros
    always_comb begin
        in_shift  = (state_q == SER_SHIFT);
        ser_valid = in_shift;
        ser_a     = in_shift & sh_a_q[OUT_IDX];
        ser_b     = in_shift & sh_b_q[OUT_IDX];
        ser_first = in_shift && (cnt_q == CNT_TOP);
        ser_last  = in_shift && (cnt_q == '0);
        in_ready  = !in_shift || (ser_last && ser_ready);
        accept    = in_valid && in_ready;
    end

endmodule

// File: tb/tb_serial_word_serializer.sv
// Self-checking bench for serial_word_serializer (W=8): directed table, corner sequences, random stream.
module tb_serial_word_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         ser_valid;
    logic         ser_ready;
    logic         ser_a;
    logic         ser_b;
    logic         ser_first;
    logic         ser_last;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_word_serializer #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_a     (ser_a),
        .ser_b     (ser_b),
        .ser_first (ser_first),
        .ser_last  (ser_last)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Bit position within the word that goes out as the k-th transfer
    function automatic int ord_idx(input int k);
`ifdef SERIALIZER_LSB_FIRST_EN
        return k;
`else
        return W - 1 - k;
`endif
    endfunction

    function automatic logic obit(input logic [W-1:0] v, input int k);
        return v[ord_idx(k)];
    endfunction

    // Inputs are applied 2 time units after a rising edge, outputs checked 1 unit later
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic iv, input logic sr, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid  = iv;
        ser_ready = sr;
        in_a      = a;
        in_b      = b;
        #1;
    endtask

    // One full word with ser_ready held high; checks every transfer and the trailing idle cycle
    task automatic run_word(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        drive(1'b1, 1'b1, a, b);
        chk({tag, "_acc_ready"}, in_ready, 1'b1);
        next_cycle();
        for (int k = 0; k < W; k++) begin
            drive(1'b0, 1'b1, '0, '0);
            chk({tag, "_valid"}, ser_valid, 1'b1);
            chk({tag, "_a"}, ser_a, obit(a, k));
            chk({tag, "_b"}, ser_b, obit(b, k));
            chk({tag, "_first"}, ser_first, k == 0);
            chk({tag, "_last"}, ser_last, k == W - 1);
            next_cycle();
        end
        drive(1'b0, 1'b1, '0, '0);
        chk({tag, "_idle_valid"}, ser_valid, 1'b0);
        chk({tag, "_idle_ready"}, in_ready, 1'b1);
    endtask

    typedef struct {
        logic         iv;
        logic         sr;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sv;
        logic         sa;
        logic         sb;
        logic         f;
        logic         l;
        logic         ir;
    } vec_t;

    vec_t tbl[W+2];

    initial begin
        logic [W-1:0] wa;
        logic [W-1:0] wb;
        logic [W-1:0] q_a[$];
        logic [W-1:0] q_b[$];
        logic [W-1:0] acc_a;
        logic [W-1:0] acc_b;
        logic [W-1:0] exp_a;
        logic [W-1:0] exp_b;
        logic         offering;
        logic         prev_stall;
        logic         prev_a;
        logic         prev_b;
        int           verdict;
        int           bitpos;
        int           n_sent;
        int           n_recv;
        int           cyc;
        int           idx;

        // Single-word table: row 0 is the acceptance cycle, rows 1..W the bits, row W+1 idle
        wa = 8'hA5;
        wb = 8'hA4;
        tbl[0] = '{1'b1, 1'b1, wa, wb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < W; k++)
            tbl[k+1] = '{1'b0, 1'b1, '0, '0, 1'b1, obit(wa, k), obit(wb, k),
                         k == 0, k == W - 1, k == W - 1};
        tbl[W+1] = '{1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        #10;
        chk("reset_valid", ser_valid, 1'b0);
        chk("reset_a", ser_a, 1'b0);
        chk("reset_b", ser_b, 1'b0);
        chk("reset_first", ser_first, 1'b0);
        chk("reset_last", ser_last, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        for (int i = 0; i < W + 2; i++) begin
            drive(tbl[i].iv, tbl[i].sr, tbl[i].a, tbl[i].b);
            chk($sformatf("tbl%0d_valid", i), ser_valid, tbl[i].sv);
            chk($sformatf("tbl%0d_a", i), ser_a, tbl[i].sa);
            chk($sformatf("tbl%0d_b", i), ser_b, tbl[i].sb);
            chk($sformatf("tbl%0d_first", i), ser_first, tbl[i].f);
            chk($sformatf("tbl%0d_last", i), ser_last, tbl[i].l);
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].ir);
            next_cycle();
        end
        $display("txn single_word a=%0h b=%0h done", wa, wb);

        // Back-to-back: second pair waits with valid high during the whole first word
        for (int c = 0; c <= 2 * W + 1; c++) begin
            if (c == 0)      drive(1'b1, 1'b1, 8'hA5, 8'hA4);
            else if (c <= W) drive(1'b1, 1'b1, 8'h0F, 8'hF0);
            else             drive(1'b0, 1'b1, '0, '0);
            if (c <= W)
                chk($sformatf("b2b%0d_in_ready", c), in_ready, (c == 0) || (c == W));
            if (c > W && c <= 2 * W) begin
                chk($sformatf("b2b%0d_valid", c), ser_valid, 1'b1);
                chk($sformatf("b2b%0d_a", c), ser_a, obit(8'h0F, c - W - 1));
                chk($sformatf("b2b%0d_b", c), ser_b, obit(8'hF0, c - W - 1));
                chk($sformatf("b2b%0d_first", c), ser_first, c == W + 1);
            end
            if (c == 2 * W + 1)
                chk("b2b_end_valid", ser_valid, 1'b0);
            next_cycle();
        end
        $display("txn back_to_back second a=0f b=f0 done");

        // Stall: ser_ready low during cycles 4..6, word finishes at cycle 11
        wa = 8'h5A;
        wb = 8'h3C;
        for (int c = 0; c <= W + 4; c++) begin
            if (c == 0) drive(1'b1, 1'b1, wa, wb);
            else        drive(1'b0, !(c >= 4 && c <= 6), '0, '0);
            if (c >= 1 && c <= W + 3) begin
                idx = (c <= 4) ? c - 1 : (c <= 7) ? 3 : c - 4;
                chk($sformatf("stall%0d_valid", c), ser_valid, 1'b1);
                chk($sformatf("stall%0d_a", c), ser_a, obit(wa, idx));
                chk($sformatf("stall%0d_b", c), ser_b, obit(wb, idx));
                chk($sformatf("stall%0d_first", c), ser_first, idx == 0);
                chk($sformatf("stall%0d_last", c), ser_last, idx == W - 1);
                chk($sformatf("stall%0d_in_ready", c), in_ready, c == W + 3);
            end
            if (c == W + 4)
                chk("stall_end_valid", ser_valid, 1'b0);
            next_cycle();
        end
        $display("txn stall a=%0h b=%0h done", wa, wb);

        // Asynchronous reset in the middle of a word
        drive(1'b1, 1'b1, 8'h5A, 8'h3C);
        next_cycle();
        drive(1'b0, 1'b1, '0, '0);
        next_cycle();
        next_cycle();
        next_cycle();
        chk("pre_rst_valid", ser_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", ser_valid, 1'b0);
        chk("async_rst_in_ready", in_ready, 1'b1);
        chk("async_rst_first", ser_first, 1'b0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        run_word("after_rst", 8'hFF, 8'h00);
        next_cycle();
        $display("txn reset_recovery a=ff b=00 done");

        run_word("one", 8'h01, 8'h80);
        next_cycle();
        $display("txn order a=01 b=80 done");

        // Random stream against a queue model plus a bit-serial comparator model
        n_sent = 0;
        n_recv = 0;
        cyc = 0;
        bitpos = 0;
        acc_a = '0;
        acc_b = '0;
        verdict = 0;
        offering = 1'b0;
        prev_stall = 1'b0;
        prev_a = 1'b0;
        prev_b = 1'b0;
        wa = '0;
        wb = '0;
        while (n_recv < 200 && cyc < 20000) begin
            if (!offering && n_sent < 200 && $urandom_range(0, 9) < 7) begin
                offering = 1'b1;
                wa = W'($urandom);
                wb = ($urandom_range(0, 3) == 0) ? wa : W'($urandom);
            end
            drive(offering, $urandom_range(0, 3) != 0, wa, wb);
            if (prev_stall) begin
                chk("rnd_stall_a", ser_a, prev_a);
                chk("rnd_stall_b", ser_b, prev_b);
            end
            prev_stall = ser_valid && !ser_ready;
            prev_a = ser_a;
            prev_b = ser_b;
            if (in_valid && in_ready) begin
                q_a.push_back(wa);
                q_b.push_back(wb);
                n_sent++;
                offering = 1'b0;
            end
            if (ser_valid && ser_ready) begin
                chk("rnd_first", ser_first, bitpos == 0);
                chk("rnd_last", ser_last, bitpos == W - 1);
                if (bitpos == 0) verdict = 0;
                acc_a[ord_idx(bitpos)] = ser_a;
                acc_b[ord_idx(bitpos)] = ser_b;
`ifdef SERIALIZER_LSB_FIRST_EN
                if (ser_a != ser_b) verdict = ser_a ? 2 : 1;
`else
                if (verdict == 0 && ser_a != ser_b) verdict = ser_a ? 2 : 1;
`endif
                bitpos++;
                if (bitpos == W) begin
                    bitpos = 0;
                    if (q_a.size() == 0) begin
                        chk("rnd_queue_nonempty", 1'b0, 1'b1);
                    end else begin
                        exp_a = q_a.pop_front();
                        exp_b = q_b.pop_front();
                        chk("rnd_word_a", acc_a, exp_a);
                        chk("rnd_word_b", acc_b, exp_b);
                        chk("rnd_a_less_b", verdict == 1, exp_a < exp_b);
                        chk("rnd_a_eq_b", verdict == 0, exp_a == exp_b);
                        chk("rnd_a_greater_b", verdict == 2, exp_a > exp_b);
                        $display("txn rnd%0d a=%0h b=%0h got_a=%0h got_b=%0h", n_recv, exp_a, exp_b, acc_a, acc_b);
                    end
                    n_recv++;
                end
            end
            next_cycle();
            cyc++;
        end
        chk("rnd_words_completed", n_recv, 200);
        chk("rnd_queue_drained", q_a.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_word_serializer.md
Name: serial_word_serializer

Overview:
- Parallel-to-serial front end for the serial comparators. Accepts a pair of W-bit operands over a valid/ready handshake and streams them out one bit pair per cycle, MSB first.
- The output bit pair drives the comparator's a/b inputs directly.
- Emits ser_first/ser_last framing so the consumer can restart its comparison (use ser_first as a synchronous clear) and sample its verdict.

Parameters:
- W, 8, operand width in bits; legal range 2..64.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream offers an operand pair.
- in_ready  output  1  block can accept a pair this cycle.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- ser_valid  output  1  ser_a/ser_b carry a valid bit pair.
- ser_ready  input  1  consumer takes the current bit pair.
- ser_a  output  1  current bit of A.
- ser_b  output  1  current bit of B.
- ser_first  output  1  current pair is bit W-1 (first of word).
- ser_last  output  1  current pair is bit 0 (last of word).

Behaviour:
- Reset (async assert, sync-released use): state IDLE, shift regs 0, bit counter 0. ser_valid=0, ser_a=0, ser_b=0, ser_first=0, ser_last=0, in_ready=1.
- A handshake occurs when valid&ready are high at a rising edge, on either side.
- State IDLE:
  - in_ready=1, ser_valid=0.
  - On an in_valid&in_ready edge: load sh_a=in_a, sh_b=in_b, cnt=W-1, go to SHIFT.
  - Latency: first bit appears on ser_* the cycle after acceptance.
- State SHIFT:
  - ser_valid=1. ser_a=sh_a[W-1], ser_b=sh_b[W-1].
  - ser_first=(cnt==W-1). ser_last=(cnt==0).
  - On ser_ready with cnt!=0: shift both regs left by 1 (zero-fill), cnt-=1.
  - Without ser_ready: hold all outputs and state unchanged (stall). ser_a/ser_b must stay stable while ser_valid&&!ser_ready.
- in_ready in SHIFT is 1 only when ser_last&&ser_ready (combinational from ser_ready), which allows back-to-back words.
- On the last-bit transfer:
  - If in_valid is also high: load the new pair, cnt=W-1, stay in SHIFT. No bubble; the next cycle shows ser_first=1.
  - Otherwise: go to IDLE; ser_valid drops the next cycle.
- Throughput: exactly W transfer cycles per word with no stalls; sustained 1 word per W cycles.
- Counter width: $clog2(W). cnt never wraps; it is reloaded on acceptance only.
- in_a/in_b are sampled only at acceptance; later changes are ignored.
- Reset mid-word: the word is discarded, outputs go to reset values immediately (async), and no partial word is resumed.
- ser_first and ser_last are never both 1 (W>=2).

Optional Feature:
- Macro SERIALIZER_LSB_FIRST_EN.
- Defined: bit order is reversed. Shift right, ser_a=sh_a[0], ser_b=sh_b[0]. ser_first marks bit 0, ser_last marks bit W-1. This feeds the LSB-first comparator. Counter and handshake are identical.
- Undefined: MSB-first as specified above.

Decomposition:
- Package serial_cmp_pkg:
  - typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;
  - localparam default width SER_W_DEFAULT=8.
- Single module; no sub-module needed. An optional testbench-only top wraps this block with the serial comparator, using ser_first as that comparator's rst.

Test Plan:
- Single word, W=8, ser_ready=1: in_a=8'hA5, in_b=8'h A4 accepted at cycle 0.
  - Cycles 1..8: ser_a=1,0,1,0,0,1,0,1 and ser_b=1,0,1,0,0,1,0,0.
  - ser_first only at cycle 1, ser_last only at cycle 8; ser_valid=0 at cycle 9.
- Back-to-back: second pair (8'h0F, 8'hF0) held valid during the first word.
  - in_ready=1 only at cycle 8.
  - Cycle 9 shows ser_first=1, ser_a=0, ser_b=1. No idle gap.
- Stall: drop ser_ready for 3 cycles at bit 4.
  - ser_a/ser_b/ser_first/ser_last hold constant.
  - The word completes at cycle 11 with bits unchanged.
  - in_ready stays 0 throughout.
- Async reset mid-word: assert rst between edges at bit 3.
  - ser_valid=0 and in_ready=1 immediately.
  - After release a new word (8'hFF, 8'h00) streams from ser_first cleanly.
- Comparator chain, 200 random pairs, with serializer feeding the MSB-first comparator (ser_first as clear):
  - At ser_last, a_less_b/a_eq_b/a_greater_b match a<b, a==b, a>b.
- SERIALIZER_LSB_FIRST_EN defined, in_a=8'h01:
  - ser_a=1 at ser_first, 0 for the remaining 7 bits.
